// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - register offsets shared by the key controller and its bench
package button_pkg;

  typedef enum logic [1:0] {
    BTN_STATE = 2'd0,
    BTN_PEND  = 2'd1,
    BTN_MASK  = 2'd2,
    BTN_ESEL  = 2'd3
  } btn_reg_e;

  localparam int unsigned BTN_CNT_W = 8;

endpackage

// File: rtl/button_ctrl_if.sv
// rtl/button_ctrl_if.sv - MMIO register bus between CPU and key controller
interface button_ctrl_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one key: 2-flop synchroniser, tick-driven debounce, edge pulses
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DB_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  input  logic tick_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  logic                 sync1_q, sync2_q;
  logic [BTN_CNT_W-1:0] cnt_q, cnt_d;
  logic                 stable_q, stable_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 raw_hi;

  assign raw_hi = ~sync2_q;

  // Any agreeing tick restarts the count, so bounces never accumulate.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (tick_i) begin
      if (raw_hi == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == BTN_CNT_W'(DB_TICKS - 1)) begin
        cnt_d    = '0;
        stable_d = raw_hi;
        rise_d   = raw_hi;
        fall_d   = ~raw_hi;
      end else begin
        cnt_d = cnt_q + BTN_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/button_ctrl.sv
// rtl/button_ctrl.sv - key debounce/event controller: prescaler, registers, level irq
module button_ctrl
  import button_pkg::*;
#(
  parameter int unsigned NKEYS    = 8,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DB_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] user_key,
  button_ctrl_if.slave     bus,
  output logic             irq
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [NKEYS-1:0] stable, rise, fall;
  logic [NKEYS-1:0] pend_q, pend_d;
  logic [NKEYS-1:0] mask_q, mask_d;
  logic [NKEYS-1:0] esel_q, esel_d;
  logic             irq_q, irq_d;
  logic [NKEYS-1:0] wbits, clr, ev;
  logic             wr_en;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    button_debounce #(.DB_TICKS(DB_TICKS)) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n_i  (user_key[g]),
      .tick_i   (tick),
      .stable_o (stable[g]),
      .rise_o   (rise[g]),
      .fall_o   (fall[g])
    );
  end

  // A new event is OR-ed in after the W1C mask, so set beats clear.
  always_comb begin
    wr_en  = bus.sel & bus.we;
    wbits  = bus.wdata[NKEYS-1:0];
    ev     = (rise & ~esel_q) | (fall & esel_q);
    clr    = (wr_en && btn_reg_e'(bus.addr) == BTN_PEND) ? wbits : '0;
    pend_d = (pend_q & ~clr) | ev;
    mask_d = (wr_en && btn_reg_e'(bus.addr) == BTN_MASK) ? wbits : mask_q;
    esel_d = (wr_en && btn_reg_e'(bus.addr) == BTN_ESEL) ? wbits : esel_q;
    irq_d  = |(pend_q & mask_q);
  end

  always_comb begin
    bus.rdata = '0;
    case (btn_reg_e'(bus.addr))
      BTN_STATE: bus.rdata[NKEYS-1:0] = stable;
      BTN_PEND:  bus.rdata[NKEYS-1:0] = pend_q;
      BTN_MASK:  bus.rdata[NKEYS-1:0] = mask_q;
      BTN_ESEL:  bus.rdata[NKEYS-1:0] = esel_q;
      default:   bus.rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      esel_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      esel_q  <= esel_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_button_ctrl.sv
// tb/tb_button_ctrl.sv - directed and randomized checks of button_ctrl against a window model
module tb_button_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] keys;
  logic       irq;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         cmp_en  = 1'b0;

  button_ctrl_if bus ();

  button_ctrl #(.NKEYS(8), .TICK_DIV(TD), .DB_TICKS(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .user_key (keys),
    .bus      (bus),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Model: keys seen 2 clocks late; on each tick a key's stable level flips
  // once its last DB tick samples all disagree with it.
  logic [7:0] m_kd1 = 8'hFF, m_kd2 = 8'hFF;
  logic [7:0] m_stable = 0, m_rise = 0, m_fall = 0;
  logic [7:0] m_pend = 0, m_mask = 0, m_esel = 0;
  logic       m_irq = 0;
  logic [7:0] m_samp [8];
  int         m_edges = 0;
  logic [7:0] t_clr, t_pend, t_stab, t_rise, t_fall, t_raw;
  logic       t_irq;
  bit         t_agree;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kd1 = 8'hFF; m_kd2 = 8'hFF;
      m_stable = 0; m_rise = 0; m_fall = 0;
      m_pend = 0; m_mask = 0; m_esel = 0; m_irq = 0; m_edges = 0;
      for (int k = 0; k < 8; k++) m_samp[k] = 8'h00;
    end else begin
      m_edges++;
      t_clr  = (bus.sel && bus.we && bus.addr == 2'd1) ? bus.wdata[7:0] : 8'h00;
      t_irq  = |(m_pend & m_mask);
      t_pend = (m_pend & ~t_clr) | (m_rise & ~m_esel) | (m_fall & m_esel);
      t_stab = m_stable; t_rise = 0; t_fall = 0;
      t_raw  = ~m_kd2;
      if (m_edges % TD == 0) begin
        for (int k = 0; k < 8; k++) begin
          m_samp[k] = {m_samp[k][6:0], t_raw[k]};
          t_agree = 1'b0;
          for (int j = 0; j < DB; j++) if (m_samp[k][j] == m_stable[k]) t_agree = 1'b1;
          if (!t_agree) begin
            t_stab[k] = t_raw[k]; t_rise[k] = t_raw[k]; t_fall[k] = ~t_raw[k];
          end
        end
      end
      if (bus.sel && bus.we && bus.addr == 2'd2) m_mask = bus.wdata[7:0];
      if (bus.sel && bus.we && bus.addr == 2'd3) m_esel = bus.wdata[7:0];
      m_kd2 = m_kd1; m_kd1 = keys;
      m_pend = t_pend; m_irq = t_irq; m_stable = t_stab; m_rise = t_rise; m_fall = t_fall;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_stable};
      2'd1:    return {24'h0, m_pend};
      2'd2:    return {24'h0, m_mask};
      default: return {24'h0, m_esel};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle_rdata", bus.rdata, model_rd(bus.addr));
      chk("cycle_irq", {31'h0, irq}, {31'h0, m_irq});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    @(negedge clk);
    chk(name, bus.rdata, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    keys = 8'hFF; rst_n = 1'b0;
    bus.sel = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: reset state
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a); #1;
      chk("t1_reset_reg", bus.rdata, 32'h0);
    end
    chk("t1_reset_irq", {31'h0, irq}, 32'h0);

    // 2: key0 press, latency bound, pending and irq
    step();
    keys[0] = 1'b0; bus.addr = 2'd0; found = 0;
    for (int i = 0; i < 18 && !found; i++) begin
      step();
      @(negedge clk);
      if (bus.rdata == 32'h1) found = 1;
    end
    chk("t2_state_latency", {31'h0, found}, 32'h1);
    step();
    rd_chk("t2_pend", 2'd1, 32'h01);
    step();
    wr(2'd2, 32'hFFFF_FF01);
    @(negedge clk);
    chk("t2_irq_same", {31'h0, irq}, 32'h0);
    step();
    @(negedge clk);
    chk("t2_irq_next", {31'h0, irq}, 32'h1);
    rd_chk("t2_mask", 2'd2, 32'h01);

    // 3: bouncing key3 never qualifies
    step();
    bus.addr = 2'd0;
    for (int i = 0; i < 10; i++) begin
      keys[3] = ~keys[3];
      repeat (6) step();
    end
    repeat (8) step();
    rd_chk("t3_state", 2'd0, 32'h01);
    rd_chk("t3_pend", 2'd1, 32'h01);

    // 4: falling-edge select on key2
    step();
    wr(2'd1, 32'hFF);
    wr(2'd3, 32'h04);
    keys[2] = 1'b0;
    repeat (24) step();
    rd_chk("t4_state_press", 2'd0, 32'h05);
    rd_chk("t4_pend_press", 2'd1, 32'h00);
    step();
    keys[2] = 1'b1;
    repeat (24) step();
    rd_chk("t4_state_rel", 2'd0, 32'h01);
    rd_chk("t4_pend_rel", 2'd1, 32'h04);
    rd_chk("t4_esel", 2'd3, 32'h04);

    // 5: set beats W1C on the same cycle
    step();
    keys[0] = 1'b1;
    repeat (24) step();
    rd_chk("t5_state_rel", 2'd0, 32'h00);
    rd_chk("t5_pend_rel", 2'd1, 32'h04);
    step();
    keys[0] = 1'b0; found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      step();
      if (m_rise[0]) found = 1;
    end
    chk("t5_rise_seen", {31'h0, found}, 32'h1);
    wr(2'd1, 32'h01);
    @(negedge clk);
    chk("t5_pend_setwins", bus.rdata, 32'h05);
    step();
    wr(2'd1, 32'h01);
    @(negedge clk);
    chk("t5_pend_clr", bus.rdata, 32'h04);
    chk("t5_irq_hold", {31'h0, irq}, 32'h1);
    step();
    @(negedge clk);
    chk("t5_irq_drop", {31'h0, irq}, 32'h0);

    // 6: reset mid-debounce with key5 held
    step();
    keys[5] = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a); #1;
      chk("t6_reset_reg", bus.rdata, 32'h0);
    end
    chk("t6_reset_irq", {31'h0, irq}, 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    bus.addr = 2'd0;
    repeat (10) step();
    @(negedge clk);
    chk("t6_state_early", bus.rdata, 32'h00);
    repeat (4) step();
    @(negedge clk);
    chk("t6_state_late", bus.rdata, 32'h21);

    // Randomized traffic: slow then fast key activity, random bus, one reset
    step();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, (c < 1500) ? 40 : 8) == 0) keys[k] = ~keys[k];
      bus.sel   = ($urandom_range(0, 3) == 0);
      bus.we    = $urandom_range(0, 1) == 1;
      bus.addr  = 2'($urandom_range(0, 3));
      bus.wdata = $urandom;
      if (c == 1700) rst_n = 1'b0;
      if (c == 1703) rst_n = 1'b1;
      step();
    end
    bus.sel = 0; bus.we = 0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
